// File: rtl/i2s_tx_dec2_if.sv
// Sample bus from the interpolator/reassembly stage into the I2S output stage.
// One-cycle valid strobe qualifies both channels; downsample_2x selects 2x decimation.
interface i2s_tx_dec2_if #(
  parameter int DATA_BITS = 24
);
  logic [DATA_BITS-1:0] APSDATA_LEFT_i;
  logic [DATA_BITS-1:0] APSDATA_RIGHT_i;
  logic                 APDATA_VALID_i;
  logic                 downsample_2x;

  modport master (
    output APSDATA_LEFT_i,
    output APSDATA_RIGHT_i,
    output APDATA_VALID_i,
    output downsample_2x
  );

  modport slave (
    input APSDATA_LEFT_i,
    input APSDATA_RIGHT_i,
    input APDATA_VALID_i,
    input downsample_2x
  );
endinterface

// File: rtl/i2s_tx_dec2.sv
// Final audio output stage: optional 2x decimation, one-frame pending buffer and a
// free-running 64-BCK Philips I2S serialiser with BCK/WS derived from AMCLK.
module i2s_tx_dec2 #(
  parameter int BCK_DIV   = 2,
  parameter int DATA_BITS = 24
) (
  input  logic              AMCLK_i,
  input  logic              ARST_i,
  i2s_tx_dec2_if.slave      sbus,
  output logic              I2S_BCK,
  output logic              I2S_WS,
  output logic              I2S_DATA,
  output logic              UNDERRUN_o,
  output logic              OVERRUN_o
);

  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int PAD_W = 32 - DATA_BITS;

  logic [DIV_W-1:0]     div_cnt;
  logic [5:0]           slot;
  logic                 ph;
  logic                 pend_flag;
  logic [DATA_BITS-1:0] pend_l;
  logic [DATA_BITS-1:0] pend_r;
  logic [DATA_BITS-1:0] frame_l;
  logic [DATA_BITS-1:0] frame_r;

  logic                 div_wrap;
  logic                 fall_evt;
  logic                 load_evt;
  logic                 capture;
  logic                 consume;
  logic [5:0]           slot_nxt;
  logic [DATA_BITS-1:0] frame_l_nxt;
  logic [DATA_BITS-1:0] frame_r_nxt;
  logic [63:0]          frame_word;
  logic                 data_nxt;
  logic                 ws_nxt;

  always_comb begin
    div_wrap = (div_cnt == DIV_W'(BCK_DIV - 1));
    fall_evt = div_wrap && I2S_BCK;
    slot_nxt = slot + 6'd1;
    load_evt = fall_evt && (slot_nxt == 6'd0);

    // Decimation keeps strobes 1, 3, 5... (ph is 0 on the kept ones).
    capture  = sbus.APDATA_VALID_i && (!sbus.downsample_2x || !ph);
    consume  = load_evt && pend_flag;

    // With no pending sample the last frame is simply repeated.
    frame_l_nxt = consume ? pend_l : frame_l;
    frame_r_nxt = consume ? pend_r : frame_r;

    // Slot k of the frame is bit 63-k of this word, so indexing with ~slot
    // gives MSB-first channels in zero-padded 32-bit slots.
    frame_word = {frame_l_nxt, {PAD_W{1'b0}}, frame_r_nxt, {PAD_W{1'b0}}};
    data_nxt   = frame_word[~slot_nxt];

    // WS leads the channel data by one BCK.
    ws_nxt = (slot_nxt >= 6'd31) && (slot_nxt <= 6'd62);
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values computed above, regardless of statement order.
  always_ff @(posedge AMCLK_i) begin
    if (ARST_i) begin
      div_cnt    <= '0;
      I2S_BCK    <= 1'b0;
      I2S_WS     <= 1'b0;
      I2S_DATA   <= 1'b0;
      slot       <= 6'd63;
      ph         <= 1'b0;
      pend_flag  <= 1'b0;
      pend_l     <= '0;
      pend_r     <= '0;
      frame_l    <= '0;
      frame_r    <= '0;
      UNDERRUN_o <= 1'b0;
      OVERRUN_o  <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) begin
        I2S_BCK <= ~I2S_BCK;
      end

      if (fall_evt) begin
        slot     <= slot_nxt;
        I2S_WS   <= ws_nxt;
        I2S_DATA <= data_nxt;
      end

      if (load_evt) begin
        frame_l <= frame_l_nxt;
        frame_r <= frame_r_nxt;
      end

      if (sbus.APDATA_VALID_i) begin
        ph <= sbus.downsample_2x ? ~ph : 1'b0;
      end

      // A strobe coincident with the load refills pending after it is consumed.
      if (capture) begin
        pend_l    <= sbus.APSDATA_LEFT_i;
        pend_r    <= sbus.APSDATA_RIGHT_i;
        pend_flag <= 1'b1;
      end else if (consume) begin
        pend_flag <= 1'b0;
      end

      UNDERRUN_o <= load_evt && !pend_flag;
      OVERRUN_o  <= capture && pend_flag && !consume;
    end
  end

endmodule

// File: tb/tb_i2s_tx_dec2.sv
// Scoreboard bench for i2s_tx_dec2: a frame-level model queues expected frames and
// flag pulses; an I2S receiver decodes the serial stream and compares independently.
module tb_i2s_tx_dec2;

  localparam int BCK_DIV = 2;
  localparam int DB      = 24;
  localparam int FIRST   = 2 * BCK_DIV;    // first falling BCK edge enters slot 0
  localparam int PERIOD  = 128 * BCK_DIV;  // AMCLK cycles per frame

  logic AMCLK_i = 1'b0;
  logic ARST_i  = 1'b1;
  logic I2S_BCK, I2S_WS, I2S_DATA, UNDERRUN_o, OVERRUN_o;

  i2s_tx_dec2_if #(.DATA_BITS(DB)) bus ();

  i2s_tx_dec2 #(.BCK_DIV(BCK_DIV), .DATA_BITS(DB)) dut (
    .AMCLK_i    (AMCLK_i),
    .ARST_i     (ARST_i),
    .sbus       (bus.slave),
    .I2S_BCK    (I2S_BCK),
    .I2S_WS     (I2S_WS),
    .I2S_DATA   (I2S_DATA),
    .UNDERRUN_o (UNDERRUN_o),
    .OVERRUN_o  (OVERRUN_o)
  );

  always #5 AMCLK_i = ~AMCLK_i;

  int total = 0;
  int bad   = 0;
  int frames_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [47:0] exp_q[$];
  logic exp_under = 1'b0;
  logic exp_over  = 1'b0;

  initial begin
    int          mcyc;
    logic        m_pf, m_ph, is_load, cap;
    logic [DB-1:0] m_pl, m_pr, m_fl, m_fr;
    mcyc = 0; m_pf = 0; m_ph = 0; m_pl = '0; m_pr = '0; m_fl = '0; m_fr = '0;
    forever begin
      @(posedge AMCLK_i);
      if (ARST_i) begin
        check("frames_pending", 64'(exp_q.size() <= 1), 64'd1);
        exp_q.delete();
        mcyc = 0; m_pf = 0; m_ph = 0;
        m_pl = '0; m_pr = '0; m_fl = '0; m_fr = '0;
        exp_under = 0; exp_over = 0;
      end else begin
        mcyc++;
        is_load = (mcyc >= FIRST) && ((mcyc - FIRST) % PERIOD == 0);
        cap = bus.APDATA_VALID_i && (!bus.downsample_2x || !m_ph);
        if (bus.APDATA_VALID_i) m_ph = bus.downsample_2x ? !m_ph : 1'b0;
        exp_under = is_load && !m_pf;
        exp_over  = cap && m_pf && !is_load;
        if (is_load) begin
          if (m_pf) begin
            m_fl = m_pl; m_fr = m_pr; m_pf = 0;
          end
          exp_q.push_back({m_fl, m_fr});
        end
        if (cap) begin
          m_pl = bus.APSDATA_LEFT_i; m_pr = bus.APSDATA_RIGHT_i; m_pf = 1;
        end
      end
    end
  end

  // ---------------- I2S receiver / monitor ----------------
  task automatic finish_frame(input logic [63:0] rx_d, input logic [63:0] rx_w);
    logic [47:0] e;
    logic [63:0] exp_ws;
    for (int k = 0; k < 64; k++) exp_ws[63-k] = (k >= 31) && (k <= 62);
    frames_seen++;
    check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("left_word",  64'(rx_d[63:40]), 64'(e[47:24]));
      check("right_word", 64'(rx_d[31:8]),  64'(e[23:0]));
      check("pad_bits",   64'({rx_d[39:32], rx_d[7:0]}), 64'd0);
      check("ws_pattern", rx_w, exp_ws);
    end
  endtask

  initial begin
    logic        prev_bck, prev_ws, in_frame, first_tog;
    int          nbits, cyc_since;
    logic [63:0] rx_d, rx_w;
    prev_bck = 0; prev_ws = 1; in_frame = 0; first_tog = 1;
    nbits = 0; cyc_since = -1; rx_d = '0; rx_w = '0;
    forever begin
      @(negedge AMCLK_i);
      if (ARST_i) begin
        prev_bck = 0; prev_ws = 1; in_frame = 0; first_tog = 1;
        nbits = 0; cyc_since = -1;
      end else begin
        cyc_since++;
        if (I2S_BCK !== prev_bck) begin
          check("bck_half_period", 64'(cyc_since), 64'(BCK_DIV));
          if (first_tog) check("bck_first_rise", 64'(I2S_BCK), 64'd1);
          first_tog = 0;
          cyc_since = 0;
          if (I2S_BCK) begin
            if (in_frame) begin
              rx_d = {rx_d[62:0], I2S_DATA};
              rx_w = {rx_w[62:0], I2S_WS};
              nbits++;
              if (nbits == 64) begin
                finish_frame(rx_d, rx_w);
                in_frame = 0;
              end
            end
            if (prev_ws && !I2S_WS) begin
              in_frame = 1; nbits = 0;
            end
            prev_ws = I2S_WS;
          end
        end
        prev_bck = I2S_BCK;
        if (exp_under || UNDERRUN_o) check("underrun_pulse", 64'(UNDERRUN_o), 64'(exp_under));
        if (exp_over  || OVERRUN_o)  check("overrun_pulse",  64'(OVERRUN_o),  64'(exp_over));
      end
    end
  end

  // ---------------- stimulus (inputs change 2 time units after posedge) ----------------
  task automatic step();
    @(posedge AMCLK_i);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    ARST_i = 1'b1;
    step();
    ARST_i = 1'b0;
  endtask

  task automatic strobe(input logic [DB-1:0] l, input logic [DB-1:0] r, input logic ds);
    bus.APSDATA_LEFT_i  = l;
    bus.APSDATA_RIGHT_i = r;
    bus.downsample_2x   = ds;
    bus.APDATA_VALID_i  = 1'b1;
    step();
    bus.APDATA_VALID_i  = 1'b0;
  endtask

  initial begin
    bus.APSDATA_LEFT_i  = '0;
    bus.APSDATA_RIGHT_i = '0;
    bus.APDATA_VALID_i  = 1'b0;
    bus.downsample_2x   = 1'b0;
    idle(3);

    // Idle after reset: zero frames, one underrun per frame.
    do_reset();
    #1;
    check("reset_bck",  64'(I2S_BCK),  64'd0);
    check("reset_ws",   64'(I2S_WS),   64'd0);
    check("reset_data", 64'(I2S_DATA), 64'd0);
    idle(800);

    // Single known sample before the first frame load, then held frames.
    do_reset();
    strobe(24'hA5A5A5, 24'h5A5A5A, 1'b0);
    idle(800);

    // Decimation: strobes every half frame, odd strobes transmitted.
    do_reset();
    idle(9);
    for (int i = 1; i <= 12; i++) begin
      strobe(24'(i), 24'($urandom), 1'b1);
      idle(127);
    end
    idle(300);

    // No decimation at frame rate, then faster than frame rate.
    do_reset();
    idle(9);
    for (int i = 0; i < 6; i++) begin
      strobe(24'($urandom), 24'($urandom), 1'b0);
      idle(PERIOD - 1);
    end
    for (int i = 0; i < 10; i++) begin
      strobe(24'($urandom), 24'($urandom), 1'b0);
      idle(63);
    end
    idle(300);

    // Strobe coincident with the second frame load (edge FIRST+PERIOD).
    do_reset();
    strobe(24'h111111, 24'h222222, 1'b0);        // edge 1, loaded at edge 4
    idle(97);
    strobe(24'h333333, 24'h444444, 1'b0);        // edge 99, pending
    idle(FIRST + PERIOD - 100);
    strobe(24'h555555, 24'h666666, 1'b0);        // load edge
    idle(700);

    // Random gaps, data and decimation setting.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      strobe(24'($urandom), 24'($urandom), 1'($urandom));
      idle($urandom_range(1, 300));
    end
    idle(300);

    // Reset mid-frame (around slot 40), then restart with no input.
    do_reset();
    strobe(24'($urandom), 24'($urandom), 1'b0);
    idle(168);
    check("ws_mid_frame", 64'(I2S_WS), 64'd1);
    ARST_i = 1'b1;
    @(posedge AMCLK_i);
    #1;
    check("midrst_bck",  64'(I2S_BCK),  64'd0);
    check("midrst_ws",   64'(I2S_WS),   64'd0);
    check("midrst_data", 64'(I2S_DATA), 64'd0);
    check("midrst_flags", 64'({UNDERRUN_o, OVERRUN_o}), 64'd0);
    #1;
    ARST_i = 1'b0;
    idle(800);

    do_reset();
    idle(2);
    check("frames_decoded", 64'(frames_seen >= 25), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
